// File: rtl/dvp_rx_pkg.sv
// -----------------------------------------------------------------------------
// dvp_rx_pkg
// Shared types and helpers for the DVP capture/packer slice:
//   - state_e      : capture FSM encoding
//   - vs_event_e   : vsync edge events (frame start / frame end)
//   - hr_event_e   : href edge events (line end)
//   - lanes()      : number of byte lanes in an output word
//   - *_ok()       : legal-range checks used at elaboration by the top
// -----------------------------------------------------------------------------
package dvp_rx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_VS,
        ST_ARM,
        ST_ACTIVE,
        ST_SKIP,
        ST_FLUSH
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_FRAME_START,
        EV_FRAME_END
    } vs_event_e;

    typedef enum logic {
        HR_NONE,
        HR_LINE_END
    } hr_event_e;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit dvp_dat_w_ok(input int w);
        return (w >= 1) && (w <= 8);
    endfunction

    function automatic bit data_w_ok(input int w);
        return (w >= 16) && ((w % 8) == 0);
    endfunction

    function automatic bit fifo_depth_ok(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/dvp_rx_capture_packer_fifo.sv
// -----------------------------------------------------------------------------
// pixel_word_fifo
// Synchronous FIFO for packed pixel words (word + last flag).
// Ports:
//   clk, rst          : system clock, async active-high reset
//   push_i/push_data_i: write request and data
//   pop_i             : read request (ignored when empty)
//   pop_data_o        : head-of-queue data
//   full_o, empty_o   : occupancy flags
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module pixel_word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/dvp_rx_capture_packer.sv
// -----------------------------------------------------------------------------
// dvp_rx_capture_packer
// Captures the DVP active-video byte stream (sampled on pclk_stb_i), packs it
// into DATA_W words with a frame-end marker and queues them in a small FIFO.
// Supports frame skipping, vertical crop, frame counting and sticky overflow.
// Ports:
//   clk, rst                     : system clock, async active-high reset
//   dvp_d_i, dvp_href_i,
//   dvp_vsync_i, pclk_stb_i      : DVP bus (clk-synchronous) and sample strobe
//   cfg_en_i, cfg_skip_i,
//   cfg_lines_i                  : capture enable, frames to skip, line limit
//   pxl_word_o, pxl_last_o,
//   pxl_vld_o, pxl_rdy_i         : packed word stream, valid/ready
//   frm_cnt_o                    : captured-frame counter (wraps)
//   ovf_o, ovf_clr_i             : sticky overflow and its clear (set wins)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// WAIT_VS    | after reset, wait for vertical blanking before trusting edges
// ARM        | in blanking, decide at frame start: capture, skip or idle
// ACTIVE     | packing bytes of a captured frame
// SKIP       | dropping a frame, wait for its end
// FLUSH      | push staged word and any zero-padded partial word
// -----------------------------------------------------------------------------
module dvp_rx_capture_packer
    import dvp_rx_pkg::*;
#(
    parameter int DVP_DAT_W  = 8,
    parameter int DATA_W     = 32,
    parameter int LINE_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int FRM_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DVP_DAT_W-1:0] dvp_d_i,
    input  logic                 dvp_href_i,
    input  logic                 dvp_vsync_i,
    input  logic                 pclk_stb_i,
    input  logic                 cfg_en_i,
    input  logic [3:0]           cfg_skip_i,
    input  logic [LINE_W-1:0]    cfg_lines_i,
    output logic [DATA_W-1:0]    pxl_word_o,
    output logic                 pxl_last_o,
    output logic                 pxl_vld_o,
    input  logic                 pxl_rdy_i,
    output logic [FRM_CNT_W-1:0] frm_cnt_o,
    output logic                 ovf_o,
    input  logic                 ovf_clr_i
);

    localparam int LANES  = lanes(DATA_W);
    localparam int LANE_W = $clog2(LANES);

    if (!dvp_dat_w_ok(DVP_DAT_W)) begin : g_bad_dvp_dat_w
        $error("DVP_DAT_W must be in 1..8");
    end
    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8 and at least 16");
    end
    if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    state_e              state_q;
    logic                vsync_q;
    logic                href_q;
    vs_event_e           vs_ev;
    hr_event_e           hr_ev;
    logic [7:0]          dvp_byte;
    logic [LANE_W-1:0]   lane_q;
    logic [LINE_W-1:0]   line_q;
    logic [3:0]          skip_q;
    logic [DATA_W-1:0]   asm_q;
    logic [DATA_W-1:0]   asm_d;
    logic [DATA_W-1:0]   stage_q;
    logic                stage_vld_q;
    logic                flush_ph_q;
    logic                push_q;
    logic [DATA_W:0]     push_data_q;
    logic [FRM_CNT_W-1:0] frm_cnt_q;
    logic                ovf_q;
    logic                crop_hit;
    logic                byte_wr;
    logic                partial;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W:0]     fifo_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else if (pclk_stb_i) begin
            vsync_q <= dvp_vsync_i;
            href_q  <= dvp_href_i;
        end
    end

    always_comb begin
        vs_ev = EV_NONE;
        hr_ev = HR_NONE;
        if (pclk_stb_i) begin
            if (vsync_q && !dvp_vsync_i)      vs_ev = EV_FRAME_START;
            else if (!vsync_q && dvp_vsync_i) vs_ev = EV_FRAME_END;
            if (href_q && !dvp_href_i)        hr_ev = HR_LINE_END;
        end
    end

    always_comb begin
        dvp_byte = '0;
        dvp_byte[DVP_DAT_W-1:0] = dvp_d_i;
    end

    // Assembly word with the incoming byte merged at the current lane.
    always_comb begin
        asm_d = asm_q;
        asm_d[{lane_q, 3'b000} +: 8] = dvp_byte;
    end

    assign crop_hit = (cfg_lines_i != '0) && (line_q == cfg_lines_i);
    assign byte_wr  = pclk_stb_i && dvp_href_i && !crop_hit;
    assign partial  = (lane_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT_VS;
            lane_q      <= '0;
            line_q      <= '0;
            skip_q      <= '0;
            asm_q       <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            flush_ph_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frm_cnt_q   <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                ST_WAIT_VS: begin
                    if (pclk_stb_i && dvp_vsync_i) state_q <= ST_ARM;
                end
                ST_ARM: begin
                    if (vs_ev == EV_FRAME_START && cfg_en_i) begin
                        if (skip_q != 4'd0) begin
                            skip_q  <= skip_q - 4'd1;
                            state_q <= ST_SKIP;
                        end else begin
                            state_q <= ST_ACTIVE;
                            line_q  <= '0;
                            skip_q  <= cfg_skip_i;
                        end
                    end
                end
                ST_SKIP: begin
                    if (vs_ev == EV_FRAME_END) state_q <= ST_ARM;
                end
                ST_ACTIVE: begin
                    if (vs_ev == EV_FRAME_END) begin
                        state_q    <= ST_FLUSH;
                        flush_ph_q <= 1'b0;
                    end else begin
                        if (byte_wr) begin
                            if (lane_q == LANE_W'(LANES - 1)) begin
                                // Word complete: it waits in stage so the
                                // frame's final word can still be tagged last.
                                lane_q      <= '0;
                                asm_q       <= '0;
                                stage_q     <= asm_d;
                                stage_vld_q <= 1'b1;
                                if (stage_vld_q) begin
                                    push_q      <= 1'b1;
                                    push_data_q <= {1'b0, stage_q};
                                end
                            end else begin
                                lane_q <= lane_q + LANE_W'(1);
                                asm_q  <= asm_d;
                            end
                        end
                        // Freeze the line count once the crop limit is hit so
                        // it cannot run past the limit and re-open capture.
                        if (hr_ev == HR_LINE_END && !crop_hit) begin
                            line_q <= line_q + LINE_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!flush_ph_q) begin
                        if (stage_vld_q) begin
                            push_q      <= 1'b1;
                            push_data_q <= {!partial, stage_q};
                        end
                        stage_vld_q <= 1'b0;
                        if (partial) begin
                            flush_ph_q <= 1'b1;
                        end else begin
                            frm_cnt_q <= frm_cnt_q + FRM_CNT_W'(1);
                            lane_q    <= '0;
                            asm_q     <= '0;
                            state_q   <= ST_ARM;
                        end
                    end else begin
                        // Unwritten lanes of asm_q are already zero.
                        push_q      <= 1'b1;
                        push_data_q <= {1'b1, asm_q};
                        flush_ph_q  <= 1'b0;
                        frm_cnt_q   <= frm_cnt_q + FRM_CNT_W'(1);
                        lane_q      <= '0;
                        asm_q       <= '0;
                        state_q     <= ST_ARM;
                    end
                end
                default: state_q <= ST_WAIT_VS;
            endcase
        end
    end

    pixel_word_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pxl_vld_o = !fifo_empty;
    assign fifo_pop  = pxl_vld_o && pxl_rdy_i;

    // Gate the head word so outputs read 0 whenever nothing is queued.
    assign pxl_word_o = pxl_vld_o ? fifo_rd_data[DATA_W-1:0] : '0;
    assign pxl_last_o = pxl_vld_o ? fifo_rd_data[DATA_W] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_q && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_o     = ovf_q;
    assign frm_cnt_o = frm_cnt_q;

endmodule

// File: tb/tb_dvp_rx_capture_packer.sv
module tb_dvp_rx_capture_packer;

    localparam int DVP_DAT_W  = 8;
    localparam int DATA_W     = 32;
    localparam int LINE_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int FRM_CNT_W  = 16;
    localparam int LANES      = DATA_W / 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DVP_DAT_W-1:0] dvp_d_i = '0;
    logic                 dvp_href_i = 1'b0;
    logic                 dvp_vsync_i = 1'b0;
    logic                 pclk_stb_i = 1'b0;
    logic                 cfg_en_i = 1'b1;
    logic [3:0]           cfg_skip_i = '0;
    logic [LINE_W-1:0]    cfg_lines_i = '0;
    logic [DATA_W-1:0]    pxl_word_o;
    logic                 pxl_last_o;
    logic                 pxl_vld_o;
    logic                 pxl_rdy_i = 1'b1;
    logic [FRM_CNT_W-1:0] frm_cnt_o;
    logic                 ovf_o;
    logic                 ovf_clr_i = 1'b0;

    always #5 clk = ~clk;

    dvp_rx_capture_packer #(
        .DVP_DAT_W  (DVP_DAT_W),
        .DATA_W     (DATA_W),
        .LINE_W     (LINE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FRM_CNT_W  (FRM_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dvp_d_i     (dvp_d_i),
        .dvp_href_i  (dvp_href_i),
        .dvp_vsync_i (dvp_vsync_i),
        .pclk_stb_i  (pclk_stb_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_skip_i  (cfg_skip_i),
        .cfg_lines_i (cfg_lines_i),
        .pxl_word_o  (pxl_word_o),
        .pxl_last_o  (pxl_last_o),
        .pxl_vld_o   (pxl_vld_o),
        .pxl_rdy_i   (pxl_rdy_i),
        .frm_cnt_o   (frm_cnt_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [DATA_W:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop on each transfer, hold check while stalled.
    logic            prev_hold = 1'b0;
    logic [DATA_W:0] prev_out  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && pxl_vld_o)
                chk("hold_stable", {pxl_last_o, pxl_word_o}, prev_out);
            if (pxl_vld_o && pxl_rdy_i) begin
                chk("word_pending", sb_q.size() != 0, 1);
                if (sb_q.size() != 0)
                    chk("word", {pxl_last_o, pxl_word_o}, sb_q.pop_front());
            end
            prev_hold = pxl_vld_o && !pxl_rdy_i;
            prev_out  = {pxl_last_o, pxl_word_o};
        end
    end

    // One DVP sample: strobe every 4 clk cycles.
    task automatic stb(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge clk); #1;
        dvp_vsync_i = vs;
        dvp_href_i  = hr;
        dvp_d_i     = d;
        pclk_stb_i  = 1'b1;
        @(posedge clk); #1;
        pclk_stb_i  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input int lines, input int bpl, input logic [7:0] base);
        logic [7:0] v;
        v = base;
        repeat (3) stb(1'b1, 1'b0, 8'h00);
        repeat (2) stb(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < lines; l++) begin
            for (int b = 0; b < bpl; b++) begin
                stb(1'b0, 1'b1, v);
                v++;
            end
            repeat (2) stb(1'b0, 1'b0, 8'h00);
        end
        stb(1'b1, 1'b0, 8'h00);
        repeat (2) stb(1'b1, 1'b0, 8'h00);
    endtask

    // Reference packer: bytes base, base+1, ... over the kept lines.
    task automatic expect_frame(input int lines, input int bpl, input logic [7:0] base,
                                input int max_lines, input int max_words);
        logic [7:0]        v;
        logic [DATA_W-1:0] w;
        int                n_lines;
        int                n;
        int                pushed;
        n_lines = (max_lines != 0 && max_lines < lines) ? max_lines : lines;
        n       = n_lines * bpl;
        v       = base;
        pushed  = 0;
        for (int i = 0; i < n; i += LANES) begin
            w = '0;
            for (int k = 0; k < LANES; k++) begin
                if (i + k < n) begin
                    w[8*k +: 8] = v;
                    v++;
                end
            end
            if (pushed < max_words) begin
                sb_q.push_back({(i + LANES >= n), w});
                pushed++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        pclk_stb_i  = 1'b0;
        dvp_vsync_i = 1'b0;
        dvp_href_i  = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk); #1;
        chk({tag, "_drain"}, sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        chk("rst_vld",  pxl_vld_o,  0);
        chk("rst_word", pxl_word_o, 0);
        chk("rst_last", pxl_last_o, 0);
        chk("rst_frm",  frm_cnt_o,  0);
        chk("rst_ovf",  ovf_o,      0);
        rst = 1'b0;

        // 2 lines x 6 bytes
        expect_frame(2, 6, 8'h01, 0, 99);
        send_frame(2, 6, 8'h01);
        wait_drain("t1");
        chk("t1_frm", frm_cnt_o, 1);

        // 1 line x 5 bytes: partial word flushed zero-padded
        do_reset();
        expect_frame(1, 5, 8'h01, 0, 99);
        send_frame(1, 5, 8'h01);
        wait_drain("t2");
        chk("t2_frm", frm_cnt_o, 1);

        // skip 2: frames 0 and 3 of 6
        do_reset();
        cfg_skip_i = 4'd2;
        for (int f = 0; f < 6; f++) begin
            if (f == 0 || f == 3) expect_frame(1, 4, 8'(16 * f), 0, 99);
            send_frame(1, 4, 8'(16 * f));
        end
        wait_drain("t3");
        chk("t3_frm", frm_cnt_o, 2);
        cfg_skip_i = 4'd0;

        // overflow with output stalled
        do_reset();
        pxl_rdy_i = 1'b0;
        expect_frame(1, 28, 8'h01, 0, FIFO_DEPTH);
        send_frame(1, 28, 8'h01);
        chk("t4_ovf",  ovf_o,     1);
        chk("t4_vld",  pxl_vld_o, 1);
        chk("t4_head", {pxl_last_o, pxl_word_o}, {1'b0, 32'h04030201});
        @(posedge clk); #1;
        ovf_clr_i = 1'b1;
        @(posedge clk); #1;
        ovf_clr_i = 1'b0;
        chk("t4_ovf_clr",   ovf_o, 0);
        chk("t4_head_clr",  {pxl_last_o, pxl_word_o}, {1'b0, 32'h04030201});
        pxl_rdy_i = 1'b1;
        wait_drain("t4");
        chk("t4_frm", frm_cnt_o, 1);

        // crop to 1 line
        do_reset();
        cfg_lines_i = LINE_W'(1);
        expect_frame(2, 4, 8'hA0, 1, 99);
        send_frame(2, 4, 8'hA0);
        wait_drain("t5");
        chk("t5_frm", frm_cnt_o, 1);
        cfg_lines_i = '0;

        // reset mid-line with a word queued
        pxl_rdy_i = 1'b0;
        repeat (3) stb(1'b1, 1'b0, 8'h00);
        repeat (2) stb(1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 8; b++) stb(1'b0, 1'b1, 8'(8'h30 + b));
        repeat (2) stb(1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 3; b++) stb(1'b0, 1'b1, 8'(8'h38 + b));
        chk("t6_pre_vld",  pxl_vld_o,  1);
        chk("t6_pre_word", pxl_word_o, 32'h33323130);
        chk("t6_pre_frm",  frm_cnt_o,  1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_vld",  pxl_vld_o,  0);
        chk("t6_rst_word", pxl_word_o, 0);
        chk("t6_rst_last", pxl_last_o, 0);
        chk("t6_rst_frm",  frm_cnt_o,  0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        pxl_rdy_i = 1'b1;
        for (int b = 0; b < 5; b++) stb(1'b0, 1'b1, 8'(8'h3B + b));
        repeat (2) stb(1'b0, 1'b0, 8'h00);
        stb(1'b1, 1'b0, 8'h00);
        expect_frame(2, 4, 8'h50, 0, 99);
        send_frame(2, 4, 8'h50);
        wait_drain("t6");
        chk("t6_frm", frm_cnt_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dvp_rx_capture_packer.md
Name: dvp_rx_capture_packer

Overview:
Parametrised successor to the DVP front-end capture path. Works in the system clock domain on DVP bus samples qualified by the pclk-sync strobe. Packs the active-video byte stream into DATA_W words with a frame-end marker. Adds per-frame decimation (frame skip), vertical crop, an output FIFO with valid/ready, a captured-frame counter and sticky overflow reporting. It sits between dvp_pclk_sync and the pixel processing/AXI4 TX chain.

Parameters:
DVP_DAT_W, 8, DVP data width; legal range 1..8; each sample is zero-extended to one byte lane.
DATA_W, 32, output word width; multiple of 8, at least 16; LANES = DATA_W/8.
LINE_W, 12, width of the line counter and of cfg_lines_i.
FIFO_DEPTH, 4, output FIFO depth in words; power of 2, at least 2.
FRM_CNT_W, 16, width of the captured-frame counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
dvp_d_i  in  DVP_DAT_W  DVP data, already synchronised to clk
dvp_href_i  in  1  line valid, active-high
dvp_vsync_i  in  1  vertical sync, high during vertical blanking
pclk_stb_i  in  1  one-cycle strobe per pclk rising edge (from dvp_pclk_sync); all DVP inputs are sampled only on this strobe
cfg_en_i  in  1  capture enable, sampled at frame start only
cfg_skip_i  in  4  number of frames dropped after each captured frame
cfg_lines_i  in  LINE_W  maximum lines captured per frame; 0 means unlimited
pxl_word_o  out  DATA_W  packed word; byte k is in bits [8k+7:8k], earliest byte in lane 0
pxl_last_o  out  1  marks the last word of the frame
pxl_vld_o  out  1  output valid
pxl_rdy_i  in  1  output ready
frm_cnt_o  out  FRM_CNT_W  count of captured frames; wraps
ovf_o  out  1  sticky overflow flag
ovf_clr_i  in  1  clears ovf_o; if a set event occurs in the same cycle, set wins

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0; FSM in WAIT_VS; FIFO empty; lane counter, line counter and skip counter 0.
- Edge detection: registered vsync and href are updated only on pclk_stb_i.
  - Frame start = vsync falling edge.
  - Frame end = vsync rising edge.
  - Line end = href falling edge.
- FSM states: WAIT_VS, ARM, ACTIVE, SKIP, FLUSH.
  - WAIT_VS: wait for vsync=1, then go to ARM. Guarantees that capture never starts mid-frame after reset.
  - ARM, on frame start:
    - if cfg_en_i=0, stay in ARM;
    - else if skip counter is not 0, decrement it and go to SKIP;
    - else go to ACTIVE, clear the line counter, and load the skip counter from cfg_skip_i.
  - SKIP: on frame end, go to ARM.
  - ACTIVE:
    - Each strobe with href=1 and the crop limit not reached writes one byte into the assembly register at the current lane, then increments the lane counter.
    - When the lane counter wraps at LANES, the completed word moves to the stage register. The previous stage word, if any, is pushed to the FIFO with last=0.
    - On line end, increment the line counter. When cfg_lines_i is not 0 and the line counter equals cfg_lines_i, ignore the remaining bytes of the frame.
    - On frame end, go to FLUSH.
  - FLUSH:
    - Cycle 1: push the stage word with last=0 if a partial word exists, otherwise with last=1.
    - Cycle 2: if a partial word exists, push it zero-padded with last=1.
    - Then increment frm_cnt_o, clear the lane counter, and go to ARM.
    - A frame with zero bytes pushes nothing but is still counted.
    - FLUSH lasts at most 2 cycles. The DVP blanking interval guarantees no strobes arrive during FLUSH.
- Latency: a word appears on pxl_vld_o 2 cycles after its completion strobe, provided the next word has completed or FLUSH has been entered, and the FIFO is non-empty-path clear.
- Handshake: pxl_vld_o = FIFO not empty. A word is transferred when pxl_vld_o and pxl_rdy_i are both 1. pxl_word_o and pxl_last_o stay stable while pxl_vld_o=1 and pxl_rdy_i=0.
- Overflow: a push into a full FIFO drops that word, including a last word, and sets ovf_o. A simultaneous pop and push when the FIFO is full is accepted with no overflow.
- Configuration changes mid-frame take effect at the next ARM decision. cfg_lines_i is compared live.
- Reset asserted mid-operation discards all partial and queued data immediately.

Decomposition:
- Package dvp_rx_pkg holds:
  - the FSM state encoding;
  - the LANES constant function;
  - the edge-detect event enums;
  - the legal-range checks for DVP_DAT_W and DATA_W (elaboration asserts).
- Sub-module pixel_word_fifo:
  - synchronous FIFO of width DATA_W+1, depth FIFO_DEPTH;
  - push/pop ports, full/empty flags, simultaneous push and pop supported when full.

Test Plan:
1. DATA_W=32, pxl_rdy_i=1, one frame of 2 lines × 6 bytes 0x01..0x0C -> words 0x04030201, 0x08070605, 0x0C0B0A09 (last=1); frm_cnt_o=1.
2. One line of 5 bytes 0x01..0x05 -> 0x04030201 (last=0), then 0x00000005 (last=1).
3. cfg_skip_i=2, 6 frames of 4 bytes each -> frames 0 and 3 are emitted, each as 1 word with last=1; frm_cnt_o=2.
4. FIFO_DEPTH=4, pxl_rdy_i=0, a frame of 28 bytes -> 4 words held in the FIFO, ovf_o=1; pulse ovf_clr_i -> ovf_o=0; pxl_word_o stable throughout.
5. cfg_lines_i=1, a frame of 2 lines × 4 bytes 0xA0..0xA7 -> a single word 0xA3A2A1A0 with last=1.
6. rst pulsed mid-line during ACTIVE -> all outputs 0 in the same cycle; a partial frame in progress at release is ignored; the next full frame is captured correctly with frm_cnt_o=1.
